// File: rtl/output_ser_arb_pkg.sv
// Shared types for the output-cell round-robin serializer: FSM state codes and counter sizing.
package output_ser_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/output_ser_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Start one past the last winner so the previous owner ends up lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/output_ser_arb.sv
// Shares one out_reg output cell between NUM_REQ requesters: round-robin grant, serial word on oqi,
// cell register held clear through qrt whenever no frame bit is on the wire.
module output_ser_arb
  import output_ser_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int LSB_FIRST  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic                      busy,
  output logic                      oqi,
  output logic                      qrt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_W + 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          win_q, win_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [GAP_CNT_W-1:0]   gapcnt_q, gapcnt_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic                   done_d, busy_d, oqi_d, qrt_d;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic [DATA_W-1:0]      slice;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  assign slice = data[int'(win_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    gnt_d    = '0;
    oqi_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (|req)) begin
          state_d = ST_LOAD;
          gnt_d   = arb_gnt;
          ptr_d   = arb_idx;
          win_d   = arb_idx;
        end
      end
      ST_LOAD: begin
        // oqi is registered, so the first bit is staged here and the register holds the remainder.
        state_d  = ST_SHIFT;
        oqi_d    = head_bit(slice);
        shreg_d  = advance(slice);
        bitcnt_d = '0;
      end
      ST_SHIFT: begin
        if (bitcnt_q == CW'(DATA_W - 1)) begin
          state_d  = ST_GAP;
          gapcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
          oqi_d    = head_bit(shreg_q);
          shreg_d  = advance(shreg_q);
        end
      end
      ST_GAP: begin
        if (gapcnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so each one leaves a flop.
    done_d = (state_d == ST_SHIFT) && (bitcnt_d == CW'(DATA_W - 1));
    busy_d = (state_d != ST_IDLE);
    qrt_d  = (state_d != ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      win_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      oqi      <= 1'b0;
      qrt      <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      gnt      <= gnt_d;
      done     <= done_d;
      busy     <= busy_d;
      oqi      <= oqi_d;
      qrt      <= qrt_d;
    end
  end

endmodule

// File: tb/tb_output_ser_arb.sv
// Bench for output_ser_arb: table-driven frames, multi-cycle corner sequences, random run vs frame-level model.
module tb_output_ser_arb;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [N-1:0]  req, gnt, req2, gnt2;
  logic [N*DW-1:0] data, data2;
  logic          done, busy, oqi, qrt;
  logic          done2, busy2, oqi2, qrt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_ser_arb #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
    .gnt(gnt), .done(done), .busy(busy), .oqi(oqi), .qrt(qrt)
  );

  output_ser_arb #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .en(en), .req(req2), .data(data2),
    .gnt(gnt2), .done(done2), .busy(busy2), .oqi(oqi2), .qrt(qrt2)
  );

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   word;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; req = '0; req2 = '0; data = '0; data2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_oqi", 32'(oqi), 32'h0);
    chk("rst_qrt", 32'(qrt), 32'h1);
    next_cycle();
    rst = 1'b1;
  endtask

  // Entered one step after a rising edge with the DUT idle; the requester drops req in LOAD.
  task automatic run_frame(input logic [N-1:0] r, input logic [7:0] word,
                           input logic [N-1:0] exp_gnt, input string tag);
    logic [7:0] ser;
    int widx;
    widx = 0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) widx = i;
    en  = 1'b1;
    req = r;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = word ^ (8'h11 * 8'(i));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, "_load_qrt"}, 32'(qrt), 32'h1);
    next_cycle();
    data = ~data;
    ser = '0;
    for (int k = 0; k < DW; k++) begin
      @(negedge clk);
      ser[k] = oqi;
      chk({tag, "_shift_qrt"}, 32'(qrt), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'(k == DW - 1));
      next_cycle();
    end
    chk({tag, "_word"}, 32'(ser), 32'(word ^ (8'h11 * 8'(widx))));
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      chk({tag, "_gap_qrt"}, 32'(qrt), 32'h1);
      chk({tag, "_gap_busy"}, 32'(busy), 32'h1);
      next_cycle();
    end
    @(negedge clk);
    chk({tag, "_end_busy"}, 32'(busy), 32'h0);
    next_cycle();
  endtask

  // Frame-level reference: position within the current frame, -1 when idle.
  int         mpos, mptr, mwin;
  logic [7:0] mword;

  task automatic model_step(input logic men, input logic [N-1:0] mreq, input logic [N*DW-1:0] mdata);
    logic found;
    int c;
    if (mpos < 0) begin
      if (men && mreq != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (mptr + k) % N;
          if (!found && mreq[c]) begin
            found = 1'b1;
            mwin  = c;
          end
        end
        mptr = mwin;
        mpos = 0;
      end
    end else if (mpos == 0) begin
      mword = mdata[mwin*DW +: DW];
      mpos  = 1;
    end else begin
      mpos++;
      if (mpos == 1 + DW + GAP) mpos = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    int gcyc[$];
    int gidx[$];
    bit seen;
    logic [7:0] ser2;
    logic [N-1:0] egnt;
    logic ebusy, eqrt, eoqi, edone, eshift;

    tbl[0] = '{4'b0001, 8'hA5, 4'b0001};
    tbl[1] = '{4'b1111, 8'h3C, 4'b0010};
    tbl[2] = '{4'b1001, 8'h5A, 4'b1000};
    tbl[3] = '{4'b1001, 8'hC3, 4'b0001};
    tbl[4] = '{4'b0110, 8'hFF, 4'b0010};
    tbl[5] = '{4'b0100, 8'h00, 4'b0100};
    tbl[6] = '{4'b0011, 8'h81, 4'b0001};

    do_reset();
    for (int t = 0; t < 7; t++) run_frame(tbl[t].req, tbl[t].word, tbl[t].exp_gnt, $sformatf("tbl%0d", t));

    // Reset during SHIFT: outputs clear at once and the pointer restarts at NUM_REQ-1.
    en = 1'b1; req = 4'b0001; data = {4{8'hA5}};
    next_cycle();
    req = '0;
    repeat (5) next_cycle();
    #2 rst = 1'b0;
    #1;
    chk("midrst_qrt", 32'(qrt), 32'h1);
    chk("midrst_oqi", 32'(oqi), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_nodone", 32'(seen), 32'h0);
    next_cycle();
    rst = 1'b1; req = 4'b0011;
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("midrst_ptr_gnt", 32'(gnt), 32'b0001);
    repeat (14) next_cycle();
    @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'h0);

    // en low blocks grants; once granted, dropping en does not cut the frame.
    next_cycle();
    en = 1'b0; req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("en0_gnt", 32'(gnt), 32'h0);
      chk("en0_busy", 32'(busy), 32'h0);
      next_cycle();
    end
    en = 1'b1;
    @(negedge clk);
    chk("en1_pre_gnt", 32'(gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("en1_gnt", 32'(gnt), 32'b0100);
    next_cycle();
    next_cycle();
    en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      next_cycle();
    end
    chk("en_drop_done", 32'(seen), 32'h1);
    @(negedge clk);
    chk("en_drop_idle_busy", 32'(busy), 32'h0);
    chk("en_drop_idle_gnt", 32'(gnt), 32'h0);
    next_cycle();
    req = '0;

    // All four requesting continuously: rotation 0,1,2,3,0 on a 12-cycle period.
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk("rr_onehot", 32'($onehot0(gnt)), 32'h1);
      if (gnt != '0) begin
        gcyc.push_back(c);
        for (int i = 0; i < N; i++) if (gnt[i]) gidx.push_back(i);
      end
      next_cycle();
    end
    chk("rr_count", 32'(gcyc.size()), 32'd5);
    for (int g = 0; g < gcyc.size() && g < 5; g++) begin
      chk("rr_idx", 32'(gidx[g]), 32'(g % N));
      chk("rr_cycle", 32'(gcyc[g]), 32'(1 + 12 * g));
    end

    // MSB-first instance: 8'h80 puts its only set bit first on the wire.
    do_reset();
    en = 1'b1; req2 = 4'b0001; data2 = {24'($urandom), 8'h80};
    @(negedge clk);
    next_cycle();
    req2 = '0;
    @(negedge clk);
    chk("msb_gnt", 32'(gnt2), 32'b0001);
    next_cycle();
    ser2 = '0;
    for (int k = 0; k < DW; k++) begin
      @(negedge clk);
      ser2[7-k] = oqi2;
      next_cycle();
    end
    chk("msb_word", 32'(ser2), 32'h80);

    // Random traffic compared cycle by cycle against the frame-level model.
    do_reset();
    mpos = -1; mptr = N - 1; mwin = 0; mword = '0;
    for (int c = 0; c < 800; c++) begin
      req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      en   = ($urandom_range(0, 7) != 0);
      data = $urandom;
      @(negedge clk);
      eshift = (mpos >= 1) && (mpos <= DW);
      egnt   = (mpos == 0) ? 4'(1 << mwin) : 4'h0;
      ebusy  = (mpos >= 0);
      eqrt   = !eshift;
      eoqi   = eshift ? mword[mpos-1] : 1'b0;
      edone  = (mpos == DW);
      chk("rand_outputs", {23'h0, gnt, done, busy, oqi, qrt, 1'b0},
          {23'h0, egnt, edone, ebusy, eoqi, eqrt, 1'b0});
      @(posedge clk);
      model_step(en, req, data);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_ser_arb.md
Name: output_ser_arb

Overview:
Round-robin arbiter and serializer that shares one output cell, configured in out_reg mode, between NUM_REQ fabric requesters.
- Each granted requester transmits one DATA_W-bit word serially on the cell data input (oqi).
- Between frames the block holds the cell register cleared via qrt.
- Sits in fabric logic and drives the output cell's OQI/QRT pins; the cell's IQC pin shares clk.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, bits per frame (1..32)
GAP_CYCLES, 2, cycles of qrt-held idle gap after each frame (1..15)
LSB_FIRST, 1, 1 = shift bit 0 first, 0 = bit DATA_W-1 first

Ports:
clk  input  1  block clock; also clocks the output cell (IQC)
rst  input  1  asynchronous, active-low reset
en  input  1  arbitration enable; 0 blocks new grants, a frame in progress completes
req  input  NUM_REQ  per-requester transmit request, level
data  input  NUM_REQ*DATA_W  per-requester word; slice i = data[i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, registered, asserted exactly one cycle (LOAD)
done  output  1  one-cycle pulse on the last SHIFT cycle of a frame
busy  output  1  high in every state except IDLE
oqi  output  1  serial data to output cell OQI
qrt  output  1  active-high clear to output cell register (QRT)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, done=0, busy=0, oqi=0, qrt=1, shift register=0, bit counter=0, last-grant pointer=NUM_REQ-1 (index 0 highest priority). Reset mid-frame aborts immediately; no done pulse is issued.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: qrt=1, oqi=0. If en=1 and |req, the winner is chosen by round-robin, searching from (ptr+1) mod NUM_REQ upward with wrap. Next state is LOAD with gnt=onehot(winner), and ptr is updated to the winner. If en=0 or req=0, stay in IDLE.
- LOAD (1 cycle): gnt high. data slice of the winner is captured into the shift register at the end of the cycle. qrt=1, oqi=0. Next state is SHIFT with counter=0.
  - The winner choice is fixed at IDLE. A requester dropping req during LOAD is still served with its data as sampled in LOAD.
  - Requesters must hold data stable through LOAD and should drop req the cycle after gnt. req seen in LOAD is ignored.
- SHIFT (DATA_W cycles): qrt=0. oqi = shift[0] (LSB_FIRST=1) or shift[DATA_W-1] (LSB_FIRST=0), driven from a register. Shift by one each cycle and increment counter.
  - done=1 when counter==DATA_W-1.
  - Then go to GAP with gap counter=0.
- GAP (GAP_CYCLES cycles): qrt=1, oqi=0. After GAP_CYCLES cycles go to IDLE.
- Cell latency: the out_reg cell adds one clk, so F2A shows bit k one cycle after oqi carries it.
- Throughput: a back-to-back frame period is 1 (IDLE) + 1 (LOAD) + DATA_W + GAP_CYCLES cycles.
- en falling during LOAD, SHIFT or GAP has no effect on the current frame; it is evaluated only in IDLE.
- Simultaneous requests: exactly one grant per frame. Fairness: every continuously-asserted req is granted within NUM_REQ frames.
- Counter widths: bit counter $clog2(DATA_W+1); gap counter 4 bits.
- All outputs are registered. No combinational path from req/data to any output.

Decomposition:
- Shared Verilog include: state encodings (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, GAP=2'd3) as localparams, included by the block and the bench.
- One sub-module, rr_arbiter (parameter N; inputs req, ptr; output one-hot grant and encoded index), purely combinational. It is reusable by other fabric controllers that share a pad.

Test Plan:
- Reset, then req=4'b0001, data0=8'hA5, LSB_FIRST=1 -> gnt=0001 at cycle 1; oqi=1,0,1,0,0,1,0,1 on cycles 2..9; done at cycle 9; qrt=0 only on cycles 2..9; busy low from cycle 12.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0, one grant every 12 cycles; never two gnt bits high.
- LSB_FIRST=0, data=8'h80 -> oqi=1 on the first SHIFT cycle, then 0 for 7 cycles.
- en=0 with req=4'b0100 -> no gnt and busy=0. Raise en -> gnt=0100 two cycles later. Drop en mid-SHIFT -> frame completes with done.
- rst asserted on SHIFT cycle 4 -> same-cycle qrt=1, oqi=0, busy=0, no done. After release with req=4'b0010 -> gnt=0010 (pointer reset, index 0 has priority if also requesting).
- req1 pulses high for IDLE only and drops in LOAD -> gnt=0010 still issued and the full frame is sent with the data sampled in LOAD.
